// File: rtl/rv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and operand-signedness decode helpers.
package rv_m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  function automatic logic rs1_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between the core (master) and the multiply/divide
// unit (slave): operands and destination in, register-file write port out.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [4:0]       rd_addr;
  logic             busy;
  logic             done;
  logic             we;
  logic [4:0]       wa;
  logic [WIDTH-1:0] wd;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_addr,
    input  busy, done, we, wa, wd
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_addr,
    output busy, done, we, wa, wd
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: one shared 2*WIDTH+1 accumulator does shift-add
// multiply or restoring divide on magnitudes, then a single fixup cycle.
module muldiv_unit
  import rv_m_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input logic            clk,
  input logic            rst,
  muldiv_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_t        state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [2:0]       f3_reg;
  logic [4:0]       rd_reg;
  logic [WIDTH-1:0] mag_a_reg, mag_b_reg;
  logic             neg_a_reg, neg_b_reg, div_zero_reg;
  logic [2*WIDTH:0] acc_reg, acc_next;
  logic [WIDTH-1:0] wd_reg;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] mul_next, div_shift, div_next;
  logic [WIDTH:0]   div_trial;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, result;

  // Magnitudes are taken at issue so the iteration is purely unsigned.
  assign a_neg = rs1_is_signed(bus.funct3) & bus.rs1_val[WIDTH-1];
  assign b_neg = rs2_is_signed(bus.funct3) & bus.rs2_val[WIDTH-1];
  assign a_mag = a_neg ? -bus.rs1_val : bus.rs1_val;
  assign b_mag = b_neg ? -bus.rs2_val : bus.rs2_val;

  always_comb begin
    mul_sum   = acc_reg[2*WIDTH:WIDTH] + {1'b0, (acc_reg[0] ? mag_a_reg : {WIDTH{1'b0}})};
    mul_next  = {1'b0, mul_sum, acc_reg[WIDTH-1:1]};
    div_shift = {acc_reg[2*WIDTH-1:0], 1'b0};
    div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, mag_b_reg};
    div_next  = div_trial[WIDTH] ? div_shift : {div_trial, div_shift[WIDTH-1:1], 1'b1};
    acc_next  = f3_reg[2] ? div_next : mul_next;
  end

  // A zero divisor leaves the remainder equal to the dividend magnitude, so only
  // the quotient needs overriding; signed overflow falls out of the magnitude path.
  always_comb begin
    prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg[2*WIDTH-1:0] : acc_reg[2*WIDTH-1:0];
    quot_fix = div_zero_reg ? {WIDTH{1'b1}}
             : ((neg_a_reg ^ neg_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]);
    rem_fix  = neg_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    case (f3_reg)
      F3_MUL:                       result = prod_fix[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              result = quot_fix;
      default:                      result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bus.busy   = 1'b1;
    bus.done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (count_reg == CW'(WIDTH - 1)) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      f3_reg       <= '0;
      rd_reg       <= '0;
      mag_a_reg    <= '0;
      mag_b_reg    <= '0;
      neg_a_reg    <= 1'b0;
      neg_b_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      acc_reg      <= '0;
      wd_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            f3_reg       <= bus.funct3;
            rd_reg       <= bus.rd_addr;
            mag_a_reg    <= a_mag;
            mag_b_reg    <= b_mag;
            neg_a_reg    <= a_neg;
            neg_b_reg    <= b_neg;
            div_zero_reg <= (bus.rs2_val == '0);
            count_reg    <= '0;
            // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
            acc_reg      <= {{(WIDTH+1){1'b0}}, (bus.funct3[2] ? a_mag : b_mag)};
          end
        end
        ST_CALC: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg + CW'(1);
        end
        ST_FIX: begin
          wd_reg <= result;
        end
        default: ;
      endcase
    end
  end

  assign bus.we = bus.done & (rd_reg != 5'd0);
  assign bus.wa = rd_reg;
  assign bus.wd = wd_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: table of single ops plus hand
// sequences for ignored starts and mid-operation reset.
module tb_muldiv_unit;
  import rv_m_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_wd;
    logic        exp_we;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_wd, input logic exp_we);
    int   lat;
    logic got;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = f3;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_addr = rd;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.funct3  = 3'($urandom);
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
    bus.rd_addr = 5'($urandom);
    check({name, " busy after start"}, 32'(bus.busy), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) got = 1'b1;
    end
    check({name, " latency"}, 32'(lat), 32'd33);
    check({name, " we"}, 32'(bus.we), 32'(exp_we));
    check({name, " wa"}, 32'(bus.wa), 32'(rd));
    check({name, " wd"}, bus.wd, exp_wd);
    $display("op %s f3=%0d a=%h b=%h rd=%0d -> wd=%h we=%0b lat=%0d", name, f3, a, b, rd,
             bus.wd, bus.we, lat + 1);
    @(posedge clk);
    #1;
    check({name, " done/busy low after"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    int done_edge;
    logic [31:0] first_wd;
    logic [4:0]  first_wa;

    vecs[0]  = '{"MUL 7*-3",        F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b1};
    vecs[1]  = '{"MULH min*min",    F3_MULH,   32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 1'b1};
    vecs[2]  = '{"MULHU max*max",   F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 1'b1};
    vecs[3]  = '{"MULHSU -1*2",     F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{"DIV -7/2",        F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 1'b1};
    vecs[5]  = '{"REM -7/2",        F3_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{"DIVU 100/7",      F3_DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       1'b1};
    vecs[7]  = '{"REMU 100/7",      F3_REMU,   32'd100,      32'd7,        5'd8,  32'd2,        1'b1};
    vecs[8]  = '{"DIV 5/0",         F3_DIV,    32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{"REM 5/0",         F3_REM,    32'd5,        32'd0,        5'd10, 32'd5,        1'b1};
    vecs[10] = '{"DIV ovf",         F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1'b1};
    vecs[11] = '{"REM ovf",         F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1'b1};
    vecs[12] = '{"MUL 3*3 rd0",     F3_MUL,    32'd3,        32'd3,        5'd0,  32'd9,        1'b0};
    vecs[13] = '{"DIVU 7/0",        F3_DIVU,   32'd7,        32'd0,        5'd13, 32'hFFFFFFFF, 1'b1};
    vecs[14] = '{"REMU 7/0",        F3_REMU,   32'd7,        32'd0,        5'd14, 32'd7,        1'b1};
    vecs[15] = '{"DIV -7/0",        F3_DIV,    32'hFFFFFFF9, 32'd0,        5'd15, 32'hFFFFFFFF, 1'b1};
    vecs[16] = '{"REM -7/0",        F3_REM,    32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFF9, 1'b1};
    vecs[17] = '{"MULHSU min*max",  F3_MULHSU, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1'b1};
    vecs[18] = '{"DIV 7/-2",        F3_DIV,    32'd7,        32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD, 1'b1};
    vecs[19] = '{"REM 7/-2",        F3_REM,    32'd7,        32'hFFFFFFFE, 5'd31, 32'd1,        1'b1};

    bus.start   = 1'b0;
    bus.funct3  = 3'd0;
    bus.rs1_val = 32'd0;
    bus.rs2_val = 32'd0;
    bus.rd_addr = 5'd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy/done/we", {29'd0, bus.busy, bus.done, bus.we}, 32'd0);
    check("reset wa", 32'(bus.wa), 32'd0);
    check("reset wd", bus.wd, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp_wd, vecs[i].exp_we);
    end

    // Second start during CALC and a start during DONE must both be ignored.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = F3_MUL;
    bus.rs1_val = 32'd5;
    bus.rs2_val = 32'd6;
    bus.rd_addr = 5'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = F3_DIV;
    bus.rs1_val = 32'd100;
    bus.rs2_val = 32'd3;
    bus.rd_addr = 5'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone     = 0;
    done_edge = 0;
    first_wd  = 32'd0;
    first_wa  = 5'd0;
    for (int e = 6; e < 80; e++) begin
      @(posedge clk);
      #1;
      if (bus.start) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          done_edge   = e;
          first_wd    = bus.wd;
          first_wa    = bus.wa;
          bus.start   = 1'b1;
          bus.funct3  = F3_MUL;
          bus.rs1_val = 32'd9;
          bus.rs2_val = 32'd9;
          bus.rd_addr = 5'd1;
        end
      end
    end
    $display("op ignored-start MUL 5*6 -> dones=%0d wd=%h wa=%0d edge=%0d", ndone, first_wd,
             first_wa, done_edge);
    check("ignored start done count", 32'(ndone), 32'd1);
    check("ignored start latency", 32'(done_edge), 32'd33);
    check("ignored start wd", first_wd, 32'd30);
    check("ignored start wa", 32'(first_wa), 32'd3);
    check("ignored start idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = F3_DIV;
    bus.rs1_val = 32'd1000;
    bus.rs2_val = 32'd3;
    bus.rd_addr = 5'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async reset busy/done/we", {29'd0, bus.busy, bus.done, bus.we}, 32'd0);
    check("async reset wd", bus.wd, 32'd0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int e = 0; e < 45; e++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.we || bus.busy) ndone++;
    end
    $display("op reset-abort DIV 1000/3 -> activity after reset=%0d", ndone);
    check("no activity after reset", 32'(ndone), 32'd0);
    run_op("MUL 2*3 after reset", F3_MUL, 32'd2, 32'd3, 5'd7, 32'd6, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the CPU datapath. It sits directly downstream of the register file read ports and consumes the `rd1`/`rd2` operand values. It computes the M-extension result over a fixed multi-cycle latency and drives the register file write port (`we`/`wa`/`wd`) for one cycle on completion. The core holds issue while `busy` is high.

## Interface
- `WIDTH`, 32: operand/result width; counter width is clog2(WIDTH)+1
- `clk` input 1: rising-edge clock
- `rst` input 1: reset, asynchronous, active-high
- `start` input 1: issue request, sampled only in IDLE
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_val` input WIDTH: operand A, fed from register file `rd1`
- `rs2_val` input WIDTH: operand B, fed from register file `rd2`
- `rd_addr` input 5: destination register
- `busy` output 1: high whenever the state is not IDLE
- `done` output 1: one-cycle completion pulse
- `we` output 1: register file write enable; equals `done`, forced 0 when latched rd is 0
- `wa` output 5: latched destination register
- `wd` output WIDTH: result, registered and held until the next completion

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE to CALC on `start`:
  - latch funct3 and rd.
  - latch operand magnitudes and sign flags: rs1 is signed for MULH/MULHSU/DIV/REM; rs2 is signed for MULH/DIV/REM.
  - clear count.
- CALC runs exactly WIDTH cycles:
  - multiply: shift-add over a 2*WIDTH accumulator.
  - divide: restoring, one quotient bit per cycle.
  - When count reaches WIDTH-1, go to FIX.
- FIX:
  - apply the sign fixup: negate the product if the signs differ; negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - select the result: low half for MUL, high half for MULH*, quotient for DIV*, remainder for REM*.
  - register the result into `wd`.
  - go to DONE.
- DONE: `done`=1 and `we`=(rd!=0) for one cycle, then return to IDLE.
- Special cases must produce these exact results, with no latency change:
  - divide by zero: DIV/DIVU give all ones; REM/REMU give rs1.
  - signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): quotient 0x80000000, REM 0.
- `start` outside IDLE is ignored, including in DONE. Operand inputs are don't-care after the start edge.

## Timing
- Start sampled at edge E0. CALC covers edges E1..E32. FIX is entered at E32 and resolved at E33. `done`/`we` are high between E33 and E34. IDLE is entered at E34.
- Latency is 34 cycles from start to write, fixed for all ops. The earliest next start is at E34.
- `busy` rises after E0 and falls after E34, covering the DONE cycle.
- Reset values: state IDLE, `busy`=0, `done`=0, `we`=0, `wa`=0, `wd`=0, all internal registers 0.
- An `rst` assertion mid-operation (any state) aborts immediately and asynchronously. No write is issued, and no pending result survives the reset.
- `start` and `rst` both high: reset wins.

## Structure
- Shared package `rv_m_pkg`:
  - funct3 localparams: `F3_MUL`..`F3_REMU`.
  - state enum `md_state_t`.
  - `XLEN`=32.
- Single module. No sub-module is natural, because the datapath shares one accumulator/shift register between multiply and divide. The sign fixup stays inline.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5 -> after 34 cycles `we`=1, `wa`=5, `wd`=0xFFFFFFEB; `done` is high for exactly one cycle.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. All complete in 34 cycles.
- rd=0 with MUL 3×3 -> `done`=1, `we`=0, `wd`=9. A second `start` pulsed during CALC -> ignored: a single `done`, and the result matches the first operands.
- `rst` asserted at cycle 10 of a DIV -> `busy`/`done`/`we` go to 0 immediately with no later write. A new MUL 2×3 after release -> `wd`=6.
